fp_div_seq: RTL
===============

FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
REQ-001 SHALL have parameter sig_width, default 23, fraction bits excluding hidden bit.
REQ-002 SHALL have parameter ex_width, default 8, exponent bits; bias = 2**(ex_width-1)-1.
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have enable  input  1  high: advance; low: all state and outputs hold.
REQ-006 SHALL have start  input  1  request; accepted only in IDLE with enable high.
REQ-007 SHALL have a, b  input  sig_width+ex_width+1 each  dividend, divisor {sign, exp, frac}.
REQ-008 SHALL have round  input  3  rounding mode: 000 RNE, 001 RTZ, 010 toward +inf, 011 toward -inf, 100 nearest ties-up, 101 away from zero.
REQ-009 SHALL have busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have done  output  1  one-cycle pulse; z and status valid that cycle and held until next accepted start.
REQ-011 SHALL have z  output  sig_width+ex_width+1  a / b.
REQ-012 SHALL have status  output  8  {0, div_by_zero_f, inexact_f, huge_f, tiny_f, nan_f, inf_f, zero_f}.

Function
REQ-013 SHALL latch a, b, round on the accepted start edge; later input changes do not affect the result.
REQ-014 SHALL implement states IDLE -> DIVIDE -> ROUND -> IDLE; DIVIDE iterates exactly sig_width+3 cycles (counter), ROUND takes one cycle.
REQ-015 SHALL produce done high beginning sig_width+4 enabled rising edges after the start edge (27 for default), then return to IDLE; done is never high two consecutive cycles.
REQ-016 SHALL ignore start while busy; start coincident with done cycle is accepted (IDLE reached at same edge).
REQ-017 SHALL compute sign = sa XOR sb; exponent = Ea - Eb + bias in ex_width+2-bit signed arithmetic.
REQ-018 SHALL divide {1,fa} by {1,fb} by restoring division, one quotient bit per DIVIDE cycle; sticky = OR of nonzero final remainder.
REQ-019 SHALL normalize: if quotient MSB is 0, shift left one and decrement exponent; guard = next bit after sig_width fraction bits, sticky includes all lower bits.
REQ-020 SHALL round per REQ-008; mantissa carry-out shifts right one and increments exponent; inexact_f = guard OR sticky.
REQ-021 SHALL flag huge_f when final exponent >= 2**ex_width-1: z = inf for RNE, ties-up, away, and directed-toward-sign; max finite otherwise; inexact_f set.
REQ-022 SHALL flag tiny_f when final exponent <= 0: z = signed zero (no subnormal output), zero_f and inexact_f set.
REQ-023 SHALL treat exponent 0 as zero (operand flush) and all-ones exponent as inf (frac 0) or NaN (frac nonzero).
REQ-024 SHALL return canonical NaN (sign 0, exp all-ones, frac MSB 1 only) with nan_f for 0/0, inf/inf, NaN operand.
REQ-025 SHALL return signed inf with inf_f and div_by_zero_f for finite nonzero / 0; signed inf with inf_f for inf / finite.
REQ-026 SHALL return signed zero with zero_f for 0 / nonzero and finite / inf.

Reset
REQ-027 SHALL, with resetn low at a rising edge, enter IDLE and clear busy, done, z, status, counter, all datapath registers, regardless of state or enable.
REQ-028 SHALL, on reset mid-DIVIDE, discard the operation; no done pulse follows.

Configuration
REQ-029 SHALL support macro FP_DIV_EARLY_EXIT_EN: when defined, special-case operands (REQ-023..026 inputs) skip DIVIDE, go IDLE -> ROUND, done at 2nd edge after start; when undefined, all operands take full REQ-015 latency with identical results.

Verification
REQ-030 SHALL check 0x3FC00000 / 0x3F000000, RNE -> z=0x40400000, status=0x00, done at edge 27.
REQ-031 SHALL check 0x3F800000 / 0x40400000: RNE -> 0x3EAAAAAB, RTZ -> 0x3EAAAAAA, inexact_f set both.
REQ-032 SHALL check 0x3F800000 / 0x00000000 -> 0x7F800000, status=0x42; 0x00000000 / 0x00000000 -> 0x7FC00000, status=0x04; latency 2 with FP_DIV_EARLY_EXIT_EN, 27 without.
REQ-033 SHALL check 0x7F000000 / 0x3E800000: RNE -> 0x7F800000 huge_f; RTZ -> 0x7F7FFFFF huge_f.
REQ-034 SHALL check start pulsed at edge 5 of busy op ignored; resetn low at edge 10 of an op -> IDLE, outputs 0, no done; enable low 3 cycles mid-op delays done by exactly 3.

Source files
------------

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-style floating-point divider, z = a / b.
// One quotient bit per cycle via restoring division, followed by a single
// normalize/round cycle. Subnormal operands are flushed to zero and
// subnormal results underflow to signed zero.
//
// Optional build macro FP_DIV_EARLY_EXIT_EN: special-case operands (zero,
// inf, NaN) bypass the DIVIDE iterations and complete on the 2nd edge after
// start. Without it every operation takes the full iterative latency.
module fp_div_seq #(
    parameter int sig_width = 23,
    parameter int ex_width  = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        start,
    input  logic [sig_width+ex_width:0] a,
    input  logic [sig_width+ex_width:0] b,
    input  logic [2:0]                  round,
    output logic                        busy,
    output logic                        done,
    output logic [sig_width+ex_width:0] z,
    output logic [7:0]                  status
);
    localparam int W    = sig_width + ex_width + 1;
    localparam int QW   = sig_width + 3;          // quotient bits produced
    localparam int MW   = sig_width + 1;          // mantissa incl. hidden bit
    localparam int RW   = sig_width + 2;          // partial remainder width
    localparam int EW   = ex_width + 2;           // signed working exponent
    localparam int CW   = $clog2(QW + 1);
    localparam int BIAS = 2**(ex_width-1) - 1;
    localparam int EMAX = 2**ex_width - 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_ROUND  = 2'd2;

    // status bit positions
    localparam int ST_ZERO = 0;
    localparam int ST_INF  = 1;
    localparam int ST_NAN  = 2;
    localparam int ST_TINY = 3;
    localparam int ST_HUGE = 4;
    localparam int ST_INEX = 5;
    localparam int ST_DBZ  = 6;

    logic [1:0]          state_r;
    logic [CW-1:0]       cnt_r;
    logic                sign_r;
    logic [EW-1:0]       exp_r;
    logic [MW-1:0]       mb_r;
    logic [RW-1:0]       rem_r;
    logic [QW-1:0]       q_r;
    logic [2:0]          rnd_r;
    logic                sp_r;
    logic [W-1:0]        sp_z_r;
    logic [7:0]          sp_st_r;

    // operand fields
    logic                sa, sb;
    logic [ex_width-1:0] ea, eb;
    logic [sig_width-1:0] fa, fb;
    logic                a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [EW-1:0]       exp_in;

    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ea = a[W-2:sig_width];
    assign eb = b[W-2:sig_width];
    assign fa = a[sig_width-1:0];
    assign fb = b[sig_width-1:0];

    // exponent 0 is zero regardless of fraction (flush); all-ones is inf/NaN
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);

    assign exp_in = EW'(ea) - EW'(eb) + EW'(BIAS);

    // special-operand classification, evaluated on the accepting edge
    logic          sp_hit;
    logic [W-1:0]  sp_z;
    logic [7:0]    sp_st;

    // Pick the special-case result; sp_hit low means a regular divide
    always_comb begin
        sp_hit = 1'b1;
        sp_z   = '0;
        sp_st  = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            // canonical quiet NaN, positive
            sp_z[W-2:sig_width] = '1;
            sp_z[sig_width-1]   = 1'b1;
            sp_st[ST_NAN]       = 1'b1;
        end else if (a_inf || b_zero) begin
            // inf/finite (incl. inf/0) is plain inf; finite/0 also raises div-by-zero
            sp_z[W-1]           = sa ^ sb;
            sp_z[W-2:sig_width] = '1;
            sp_st[ST_INF]       = 1'b1;
            sp_st[ST_DBZ]       = ~a_inf;
        end else if (a_zero || b_inf) begin
            sp_z[W-1]      = sa ^ sb;
            sp_st[ST_ZERO] = 1'b1;
        end else begin
            sp_hit = 1'b0;
        end
    end

    // restoring division step
    logic          rem_ge;
    logic [RW-1:0] rem_nxt;

    assign rem_ge  = (rem_r >= {1'b0, mb_r});
    assign rem_nxt = (rem_ge ? (rem_r - {1'b0, mb_r}) : rem_r) << 1;

    // normalize / round / range-check result
    logic            norm, g, s, inc, to_inf, huge, tiny;
    logic [MW-1:0]   mant;
    logic [MW:0]     mant_rnd;
    logic [EW-1:0]   e_n, e_f;
    logic [sig_width-1:0] frac;
    logic [W-1:0]    rz;
    logic [7:0]      rst;

    // Final result from quotient, remainder and latched rounding mode
    always_comb begin
        norm = q_r[QW-1];
        mant = norm ? q_r[QW-1:2] : q_r[QW-2:1];
        g    = norm ? q_r[1] : q_r[0];
        s    = (norm & q_r[0]) | (|rem_r);
        e_n  = norm ? exp_r : exp_r - EW'(1);

        case (rnd_r)
            3'b001:  inc = 1'b0;
            3'b010:  inc = ~sign_r & (g | s);
            3'b011:  inc = sign_r & (g | s);
            3'b100:  inc = g;
            3'b101:  inc = g | s;
            default: inc = g & (s | mant[0]);   // RNE (also for unused codes)
        endcase

        mant_rnd = {1'b0, mant} + {{MW{1'b0}}, inc};
        if (mant_rnd[MW]) begin
            // rounding overflowed to 10.00..0: renormalize
            frac = mant_rnd[sig_width:1];
            e_f  = e_n + EW'(1);
        end else begin
            frac = mant_rnd[sig_width-1:0];
            e_f  = e_n;
        end

        huge = ($signed(e_f) >= $signed(EW'(EMAX)));
        tiny = ($signed(e_f) <= $signed(EW'(0)));

        // overflow saturates to max finite only when rounding away from inf
        case (rnd_r)
            3'b001:  to_inf = 1'b0;
            3'b010:  to_inf = ~sign_r;
            3'b011:  to_inf = sign_r;
            default: to_inf = 1'b1;
        endcase

        rz       = '0;
        rst      = '0;
        rz[W-1]  = sign_r;
        if (sp_r) begin
            rz  = sp_z_r;
            rst = sp_st_r;
        end else if (huge) begin
            rst[ST_HUGE] = 1'b1;
            rst[ST_INEX] = 1'b1;
            if (to_inf) begin
                rz[W-2:sig_width] = '1;
            end else begin
                rz[W-2:sig_width]   = {{(ex_width-1){1'b1}}, 1'b0};
                rz[sig_width-1:0]   = '1;
            end
        end else if (tiny) begin
            rst[ST_TINY] = 1'b1;
            rst[ST_ZERO] = 1'b1;
            rst[ST_INEX] = 1'b1;
        end else begin
            rz[W-2:sig_width] = e_f[ex_width-1:0];
            rz[sig_width-1:0] = frac;
            rst[ST_INEX]      = g | s;
        end
    end

    // Control FSM and datapath registers; enable low freezes everything
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            sign_r  <= 1'b0;
            exp_r   <= '0;
            mb_r    <= '0;
            rem_r   <= '0;
            q_r     <= '0;
            rnd_r   <= '0;
            sp_r    <= 1'b0;
            sp_z_r  <= '0;
            sp_st_r <= '0;
            done    <= 1'b0;
            z       <= '0;
            status  <= '0;
        end else if (enable) begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        sign_r  <= sa ^ sb;
                        exp_r   <= exp_in;
                        mb_r    <= {1'b1, fb};
                        rem_r   <= {1'b0, 1'b1, fa};
                        q_r     <= '0;
                        rnd_r   <= round;
                        sp_r    <= sp_hit;
                        sp_z_r  <= sp_z;
                        sp_st_r <= sp_st;
                        cnt_r   <= '0;
`ifdef FP_DIV_EARLY_EXIT_EN
                        // specials wait one extra cycle in ROUND (cnt_r=1)
                        // so done lands on the 2nd edge after start
                        if (sp_hit) begin
                            state_r <= S_ROUND;
                            cnt_r   <= CW'(1);
                        end else begin
                            state_r <= S_DIVIDE;
                        end
`else
                        state_r <= S_DIVIDE;
`endif
                    end
                end
                S_DIVIDE: begin
                    q_r   <= {q_r[QW-2:0], rem_ge};
                    rem_r <= rem_nxt;
                    if (cnt_r == CW'(QW-1)) begin
                        cnt_r   <= '0;
                        state_r <= S_ROUND;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_ROUND: begin
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CW'(1);
                    end else begin
                        z       <= rz;
                        status  <= rst;
                        done    <= 1'b1;
                        state_r <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_r != S_IDLE);

endmodule
